// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Valid/ready data memory with programmable wait states, byte-lane steering and load extension.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into faults.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus,
  output logic               busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          commit;

  logic [31:0]   addr_q, wdata_q;
  logic          write_q, unsigned_q;
  logic [1:0]    size_q;

  logic [31:0]   a_addr, a_wdata;
  logic          a_write, a_unsigned;
  logic [1:0]    a_size;

  logic          in_range, misalign, fault;
  logic [AW-1:0] widx;
  logic [31:0]   rd_word, ld_data, st_data;
  logic [3:0]    st_be;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  logic [31:0]   mem [DEPTH_WORDS];

  assign bus.req_ready = (state == S_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state and wait counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        cnt_nxt   = CW'(WAIT_CYCLES);
        state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= CW'(1)) state_nxt = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign commit = (state_nxt == S_RESP) && (state != S_RESP);

  // With zero wait states the access resolves on the acceptance edge, before the fields are latched
  always_comb begin
    a_addr     = addr_q;
    a_wdata    = wdata_q;
    a_write    = write_q;
    a_size     = size_q;
    a_unsigned = unsigned_q;
    if (state == S_IDLE) begin
      a_addr     = bus.req_addr;
      a_wdata    = bus.req_wdata;
      a_write    = bus.req_write;
      a_size     = bus.req_size;
      a_unsigned = bus.req_unsigned;
    end
  end

  // Fault decode, load extraction and store lane steering
  always_comb begin
    in_range = ({2'b00, a_addr[31:2]} < DEPTH_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = ((a_size == 2'b01) && a_addr[0]) || ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault   = !in_range || (a_size == 2'b11) || misalign;
    widx    = a_addr[AW+1:2];
    rd_word = in_range ? mem[widx] : 32'h0;
    ld_byte = 8'(rd_word >> {a_addr[1:0], 3'b000});
    ld_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = 32'h0;
    st_data = a_wdata;
    st_be   = 4'b0000;
    case (a_size)
      2'b00: begin
        ld_data = a_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        st_data = {4{a_wdata[7:0]}};
        st_be   = 4'b0001 << a_addr[1:0];
      end
      2'b01: begin
        ld_data = a_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        st_data = {2{a_wdata[15:0]}};
        st_be   = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        ld_data = rd_word;
        st_be   = 4'b1111;
      end
      default: ;
    endcase
    if (fault || a_write) ld_data = 32'h0;
  end

  // Storage is never reset; reset only blocks a pending commit
  always_ff @(posedge clk) begin
    if (!rst && commit && a_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.rsp_valid <= (state_nxt == S_RESP);
      busy          <= (state_nxt != S_IDLE);
      if (accept) begin
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        write_q    <= bus.req_write;
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
      end
      if (commit) begin
        bus.rsp_rdata <= ld_data;
        bus.rsp_err   <= fault;
      end
    end
  end

endmodule
